// File: rtl/rr_request_arbiter.sv
// N-way request arbiter with a rotating (or fixed-LSB) priority pointer,
// a valid/ready grant register that holds under stall, and lock-based re-grant.
module rr_request_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter bit RR_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [NUM_REQ-1:0] req,
  input  logic               lock,
  output logic               gnt_valid,
  input  logic               gnt_ready,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt_onehot
);

  logic               gnt_valid_reg;
  logic [IDX_W-1:0]   gnt_idx_reg;
  logic [NUM_REQ-1:0] gnt_onehot_reg;
  logic [IDX_W-1:0]   ptr_reg;

  logic               load;
  logic               accept;
  logic               any_req;
  logic [IDX_W-1:0]   ptr_acc;
  logic [IDX_W-1:0]   ptr_next;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] rot_req;
  logic [IDX_W-1:0]   rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] onehot_next;

  assign load    = !gnt_valid_reg || gnt_ready;
  assign accept  = gnt_valid_reg && gnt_ready;
  assign any_req = |req;

  // The pointer update from this edge's acceptance feeds this edge's arbitration,
  // so consecutive grants see the new priority without a bubble.
  always_comb begin
    ptr_acc = (gnt_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_reg + IDX_W'(1);
    if (lock) ptr_acc = gnt_idx_reg;
    ptr_next = ptr_reg;
    if (accept) ptr_next = ptr_acc;
    if (!RR_MODE) ptr_next = '0;
  end

  // Slot gi of the rotated view is requester (ptr + gi) mod NUM_REQ; the sum
  // never reaches 2*NUM_REQ, so one conditional subtract is an exact modulo.
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum = {1'b0, ptr_next} + (IDX_W + 1)'(gi);
    assign rot_idx[gi] = (sum >= (IDX_W + 1)'(NUM_REQ)) ?
                         IDX_W'(sum - (IDX_W + 1)'(NUM_REQ)) : sum[IDX_W-1:0];
    assign rot_req[gi]     = req[rot_idx[gi]];
    assign onehot_next[gi] = any_req && (win_idx == IDX_W'(gi));
  end

  always_comb begin
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) win_idx = rot_idx[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_valid_reg  <= 1'b0;
      gnt_idx_reg    <= '0;
      gnt_onehot_reg <= '0;
      ptr_reg        <= '0;
    end else if (clr) begin
      gnt_valid_reg  <= 1'b0;
      gnt_idx_reg    <= '0;
      gnt_onehot_reg <= '0;
      ptr_reg        <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (load) begin
        gnt_valid_reg  <= any_req;
        gnt_onehot_reg <= onehot_next;
        // An empty request leaves the last index in place.
        if (any_req) gnt_idx_reg <= win_idx;
      end
    end
  end

  assign gnt_valid  = gnt_valid_reg;
  assign gnt_idx    = gnt_idx_reg;
  assign gnt_onehot = gnt_onehot_reg;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Directed bench for rr_request_arbiter: 8-way round-robin, 8-way fixed priority
// and 5-way round-robin instances checked against a queue of expected grants.
module tb_rr_request_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] req = '0;
  logic       lock = 1'b0;
  logic       gnt_ready = 1'b0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;

  logic [7:0] req_f = '0;
  logic       rdy_f = 1'b0;
  logic       valid_f;
  logic [2:0] idx_f;
  logic [7:0] onehot_f;

  logic [4:0] req_5 = '0;
  logic       rdy_5 = 1'b0;
  logic       valid_5;
  logic [2:0] idx_5;
  logic [4:0] onehot_5;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
  } exp_t;

  exp_t       exp_q [$];
  logic [2:0] exp_f [$];
  logic [2:0] exp_5 [$];

  always #5 clk = ~clk;

  rr_request_arbiter #(.NUM_REQ(8), .RR_MODE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .lock(lock),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_idx(gnt_idx),
    .gnt_onehot(gnt_onehot)
  );

  rr_request_arbiter #(.NUM_REQ(8), .RR_MODE(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .req(req_f), .lock(1'b0),
    .gnt_valid(valid_f), .gnt_ready(rdy_f), .gnt_idx(idx_f),
    .gnt_onehot(onehot_f)
  );

  rr_request_arbiter #(.NUM_REQ(5), .RR_MODE(1'b1)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .req(req_5), .lock(1'b0),
    .gnt_valid(valid_5), .gnt_ready(rdy_5), .gnt_idx(idx_5),
    .gnt_onehot(onehot_5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=%0h expected=entry", tag, gnt_idx);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(gnt_valid), 32'(e.v));
      check({tag, "_idx"}, 32'(gnt_idx), 32'(e.idx));
      check({tag, "_onehot"}, 32'(gnt_onehot), e.v ? (32'd1 << e.idx) : 32'd0);
    end
    $display("txn %s req=%02h rdy=%0b lock=%0b clr=%0b -> valid=%0b idx=%0d onehot=%02h",
             tag, req, gnt_ready, lock, clr, gnt_valid, gnt_idx, gnt_onehot);
  endtask

  // Drive one cycle of inputs, queue the grant expected after the edge, then compare.
  task automatic cyc(input string tag, input logic [7:0] r, input logic rdy,
                     input logic lk, input logic c, input logic ev, input logic [2:0] ei);
    req = r; gnt_ready = rdy; lock = lk; clr = c;
    exp_q.push_back('{v: ev, idx: ei});
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{v: 1'b0, idx: 3'd0});
    check_now("reset");
    rst_n = 1'b1;

    // Rotation across all eight requesters and wrap.
    for (int k = 0; k < 10; k++) cyc("rotate", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'(k % 8));

    // Clear drops the grant; pointer restarts at 0.
    cyc("clr", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    cyc("after_clr", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);

    // Accept idx 0 with nothing pending: pointer 1, grant drops, idx kept.
    cyc("drain", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // Stall: grant 2 holds even when the requests change.
    cyc("stall_load", 8'h24, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    for (int k = 0; k < 5; k++) cyc("stall_hold", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    cyc("stall_release", 8'h24, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5);

    // Wrap from 6 to the low requesters, then empty.
    cyc("to_6", 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6);
    cyc("wrap_0", 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    cyc("wrap_1", 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
    cyc("empty", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);

    // Lock keeps priority on the accepted requester.
    cyc("lock_load", 8'h18, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
    cyc("lock_hold", 8'h18, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
    cyc("unlock", 8'h18, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    cyc("unlock_wrap", 8'h18, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);

    // Asynchronous reset in the middle of a stall.
    cyc("pre_rst", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('{v: 1'b0, idx: 3'd0});
    check_now("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_rst", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    req = '0;

    // Fixed-priority and five-way instances.
    for (int k = 0; k < 7; k++) begin
      exp_f.push_back(3'd0);
      exp_5.push_back(3'(k % 5));
    end
    req_f = 8'hFF; rdy_f = 1'b1;
    req_5 = 5'h1F; rdy_5 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic [2:0] ef;
      logic [2:0] e5;
      @(posedge clk);
      #1;
      ef = exp_f.pop_front();
      e5 = exp_5.pop_front();
      check("fixed_valid", 32'(valid_f), 32'd1);
      check("fixed_idx", 32'(idx_f), 32'(ef));
      check("fixed_onehot", 32'(onehot_f), 32'd1 << ef);
      check("n5_valid", 32'(valid_5), 32'd1);
      check("n5_idx", 32'(idx_5), 32'(e5));
      check("n5_onehot", 32'(onehot_5), 32'd1 << e5);
      $display("txn fixed idx=%0d n5 idx=%0d", idx_f, idx_5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_request_arbiter.md
Name: rr_request_arbiter

Overview:
- Registered, parametrised N-way request arbiter for the memory controller front end, e.g. per-bank or per-port command selection.
- Generalises the combinational LSB priority encoder in three ways:
  - adds a rotating round-robin priority pointer, plus a fixed-LSB mode;
  - adds a valid/ready grant handshake with a stall-stable output register;
  - adds a lock input for multi-beat ownership.
- Output is both an index and a one-hot grant.

Parameters:
- NUM_REQ, 8, number of requesters (≥2; need not be a power of two).
- IDX_W, $clog2(NUM_REQ), width of the grant index.
- RR_MODE, 1, 1 = round-robin rotating priority; 0 = fixed LSB priority (pointer pinned at 0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: drops pending grant and resets pointer.
- req  in  NUM_REQ  request vector, bit i = requester i.
- lock  in  1  sampled at grant acceptance; holds priority on the accepted requester.
- gnt_valid  out  1  registered: a grant is presented.
- gnt_ready  in  1  downstream accepts the presented grant.
- gnt_idx  out  IDX_W  registered index of the granted requester.
- gnt_onehot  out  NUM_REQ  registered one-hot of gnt_idx; all-zero when gnt_valid=0.

Behaviour:
- Reset (rst_n=0, async):
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=0.
  - Takes effect immediately, including mid-stall; a presented grant is discarded.
- clr=1 (synchronous): same values as reset at the next edge; overrides every other event in that cycle.
- Load condition: load = !gnt_valid || gnt_ready.
  - When load=1, the output register captures the arbitration result of the current req.
  - When load=0, gnt_valid, gnt_idx and gnt_onehot hold exactly, whatever req does.
- Latency: 1 cycle from req sampled to gnt_valid. Back-to-back grants are possible every cycle while gnt_ready=1.
- Arbitration:
  - Winner = first set bit of req scanning idx ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - Wrap is modulo NUM_REQ, correct for non-power-of-two NUM_REQ.
  - When RR_MODE=0, ptr stays 0, so this reduces to lowest-index-wins.
- req=0 at load: gnt_valid=0, gnt_onehot=0 and gnt_idx unchanged; ptr is unchanged.
- Acceptance = gnt_valid && gnt_ready at a rising edge. On acceptance of index k with RR_MODE=1:
  - lock=0: ptr ← (k+1) mod NUM_REQ; k=NUM_REQ-1 wraps to 0.
  - lock=1: ptr ← k, so k wins again if it still requests.
- The new ptr applies to the arbitration performed in the same edge's load. The next grant therefore uses the updated priority, with no bubble.
- A grant stands once presented. A requester dropping req while stalled does not revoke the grant; the consumer handles it.
- Invariants:
  - gnt_onehot == (gnt_valid ? 1<<gnt_idx : 0).
  - At most one bit of gnt_onehot is set.
  - gnt_idx < NUM_REQ always.
- Fairness: with RR_MODE=1, lock=0 and continuous gnt_ready, a requester that holds req is granted within NUM_REQ accepted grants.

Test Plan:
- Reset and clr:
  - Assert rst_n=0 mid-stall (gnt_valid=1, gnt_ready=0) → all outputs 0 at once.
  - clr=1 with req=8'hFF → gnt_valid=0 next cycle; ptr back to 0, so the following grant is idx 0.
- Rotation: NUM_REQ=8, req=8'hFF, gnt_ready=1 held, lock=0 → gnt_idx sequence 0,1,2,…,7,0,1; one grant per cycle after 1-cycle latency.
- Stall:
  - req=8'b0010_0100, gnt_ready=0 → gnt_idx=2 and gnt_onehot=8'h04, held for 5 cycles even if req changes to 8'h80.
  - Then gnt_ready=1 with req=8'b0010_0100 → next grant idx 5.
- Wrap and empty:
  - Accept idx 6, then req=8'b0000_0011 → grants 0, then 1.
  - Then req=0 → gnt_valid=0, gnt_onehot=0.
- Lock: req=8'b0001_1000; accept idx 3 with lock=1 → next grant idx 3; accept with lock=0 → next grant idx 4.
- Fixed mode and odd width:
  - RR_MODE=0, req=8'hFF, ready=1 → gnt_idx=0 every cycle.
  - NUM_REQ=5, req=5'b11111, RR_MODE=1 → sequence 0,1,2,3,4,0 (wrap at 4).
